// File: rtl/ds8dac_feeder.sv
// Sample-rate scheduler for the 8-bit delta-sigma DAC: small sample FIFO, one DAC code
// per sample period, click-free ramping to/from midscale on start-up, underrun and mute.
module ds8dac_feeder #(
  parameter int          DIV     = 256,
  parameter int          DEPTH   = 4,
  parameter int          LW      = 3,
  parameter int          PREFILL = 2,
  parameter logic [7:0]  MID     = 8'h80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [7:0]    dac_code,
  output logic          sample_tick,
  output logic          underrun,
  output logic [LW-1:0] fifo_level
);

  localparam int            CW   = $clog2(DIV);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] PRE  = LW'(PREFILL);

  typedef enum logic [1:0] {MUTED, RUN, STARVED} state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [7:0]    head, ramp_code;

  assign tick    = (div_cnt == LAST);
  assign s_ready = (fifo_level != FULL);
  assign push    = s_valid && s_ready;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + CW'(1);
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ramp_code = dac_code;
    if (dac_code < MID)      ramp_code = dac_code + 8'd1;
    else if (dac_code > MID) ramp_code = dac_code - 8'd1;
  end

  // Pop decision uses the pre-edge level, so a push landing in the tick cycle is not seen.
  always_comb begin
    pop = 1'b0;
    if (tick) begin
      unique case (state)
        MUTED:   pop = enable && (dac_code == MID) && (fifo_level >= PRE);
        RUN:     pop = enable && (fifo_level != '0);
        STARVED: pop = enable && (fifo_level >= PRE);
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // NOTE: sample storage is not reset; the pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MUTED;
      dac_code    <= MID;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= tick;
      underrun    <= 1'b0;
      if (tick) begin
        if (pop) begin
          dac_code <= head;
          state    <= RUN;
        end else begin
          unique case (state)
            MUTED: dac_code <= ramp_code;
            RUN: begin
              if (!enable) begin
                state <= MUTED;
              end else begin
                underrun <= 1'b1;
                state    <= STARVED;
              end
            end
            STARVED: begin
              if (!enable) state    <= MUTED;
              else         dac_code <= ramp_code;
            end
            default: state <= MUTED;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ds8dac_feeder.sv
// Scoreboard bench for ds8dac_feeder: a queue-based reference model predicts each
// per-period DAC code; a monitor compares whenever sample_tick is presented.
module tb_ds8dac_feeder;

  localparam int         DIV     = 4;
  localparam int         DEPTH   = 4;
  localparam int         LW      = 3;
  localparam int         PREFILL = 2;
  localparam logic [7:0] MID     = 8'h80;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    dac_code;
  logic          sample_tick;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  ds8dac_feeder #(.DIV(DIV), .DEPTH(DEPTH), .LW(LW), .PREFILL(PREFILL), .MID(MID)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dac_code(dac_code), .sample_tick(sample_tick),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef enum {M_MUTED, M_RUN, M_STARVED} mstate_t;
  typedef struct { logic [7:0] code; logic ur; } exp_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] mq[$];
  exp_t       exp_q[$];
  mstate_t    ms    = M_MUTED;
  logic [7:0] mcode = MID;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] toward_mid(input logic [7:0] c);
    if (c < MID) return c + 8'd1;
    if (c > MID) return c - 8'd1;
    return c;
  endfunction

  // One clock cycle: check occupancy, drive inputs, advance the model across the next edge.
  task automatic step(input logic en, input logic v, input logic [7:0] d);
    exp_t e;
    int   n;
    bit   accept;
    @(negedge clk); #1;
    check("fifo_level", int'(fifo_level), mq.size());
    check("s_ready", int'(s_ready), int'(mq.size() != DEPTH));
    enable  = en;
    s_valid = v;
    s_data  = d;
    n       = mq.size();
    accept  = v && (n != DEPTH);
    if (cyc % DIV == DIV - 1) begin
      check("tick_missing", exp_q.size(), 0);
      e.ur = 1'b0;
      case (ms)
        M_MUTED: begin
          if (en && mcode == MID && n >= PREFILL) begin
            mcode = mq.pop_front();
            ms    = M_RUN;
          end else begin
            mcode = toward_mid(mcode);
          end
        end
        M_RUN: begin
          if (!en) ms = M_MUTED;
          else if (n > 0) mcode = mq.pop_front();
          else begin
            e.ur = 1'b1;
            ms   = M_STARVED;
          end
        end
        default: begin
          if (!en) ms = M_MUTED;
          else if (n >= PREFILL) begin
            mcode = mq.pop_front();
            ms    = M_RUN;
          end else begin
            mcode = toward_mid(mcode);
          end
        end
      endcase
      e.code = mcode;
      exp_q.push_back(e);
    end
    if (accept) mq.push_back(d);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst     = 1'b1;
    s_valid = 1'b0;
    enable  = 1'b0;
    #1;
    check("rst_dac_code", int'(dac_code), int'(MID));
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_sample_tick", int'(sample_tick), 0);
    check("rst_underrun", int'(underrun), 0);
    mq.delete();
    exp_q.delete();
    ms    = M_MUTED;
    mcode = MID;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a new per-period code.
  logic [7:0] cur_code = MID;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_code = MID;
    end else if (sample_tick) begin
      if (exp_q.size() == 0) begin
        check("spurious_tick", int'(sample_tick), 0);
      end else begin
        e = exp_q.pop_front();
        check("dac_code", int'(dac_code), int'(e.code));
        check("underrun", int'(underrun), int'(e.ur));
        cur_code = e.code;
      end
    end else begin
      check("hold_code", int'(dac_code), int'(cur_code));
      check("underrun_idle", int'(underrun), 0);
    end
  end

  initial begin
    bit reached;
    int ep, vp;

    do_reset();

    // Prefill start, then a push landing exactly in an underrun tick cycle.
    step(1'b1, 1'b1, 8'h10);
    repeat (12) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h20);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (ms == M_RUN && mq.size() == 0 && (cyc % DIV == DIV - 1)) reached = 1'b1;
      else step(1'b1, 1'b0, 8'h00);
    end
    check("reach_tick_edge", int'(reached), 1);
    step(1'b1, 1'b1, 8'h55);
    repeat (20) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h30);
    step(1'b1, 1'b1, 8'h40);
    repeat (20) step(1'b1, 1'b0, 8'h00);

    // Backpressure while muted, then play out.
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
    repeat (2) step(1'b0, 1'b0, 8'h00);
    repeat (30) step(1'b1, 1'b0, 8'h00);

    // Reset mid-period while running with three entries queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i));
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (ms == M_RUN && mq.size() == 3) reached = 1'b1;
      else step(1'b1, 1'b0, 8'h00);
    end
    check("reach_run3", int'(reached), 1);
    step(1'b1, 1'b0, 8'h00);
    do_reset();

    // Randomized phases with biased enable and valid rates.
    for (int p = 0; p < 10; p++) begin
      ep = (p % 4 == 0) ? 0 : (p % 4 == 1) ? 100 : int'($urandom_range(60, 100));
      vp = int'($urandom_range(0, 100));
      for (int i = 0; i < 300; i++)
        step(int'($urandom_range(0, 99)) < ep, int'($urandom_range(0, 99)) < vp, 8'($urandom));
      if (p == 4) do_reset();
    end

    @(negedge clk); #1;
    check("final_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ds8dac_feeder.md
Name: ds8dac_feeder

Overview:
Sample-rate scheduler that sits between the synth voice/mixer engine and the 8-bit delta-sigma DAC. It buffers incoming 8-bit unsigned samples in a small FIFO and accepts them with a valid/ready handshake. It presents exactly one new DAC code per sample period, derived from the system clock. It handles start-up prefill, underrun and mute by ramping the DAC code to/from midscale, which prevents clicks at the analog output.

Parameters:
DIV, 256, clock cycles per sample period (>=2)
DEPTH, 4, FIFO depth in entries (power of 2, >=2)
LW, 3, width of fifo_level; must equal log2(DEPTH)+1
PREFILL, 2, minimum FIFO entries before playback (re)starts (1..DEPTH)
MID, 8'h80, midscale (silence) code

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  playback enable; level-sensitive, sampled only at sample ticks
s_data  in  8  unsigned sample from the mixer
s_valid  in  1  s_data valid
s_ready  out  1  feeder can accept a sample
dac_code  out  8  registered code driving the DAC input
sample_tick  out  1  one-cycle pulse in the cycle dac_code takes its per-period value
underrun  out  1  one-cycle pulse when RUN finds the FIFO empty at a tick
fifo_level  out  LW  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, immediate): div counter=0, FIFO empty (fifo_level=0), s_ready=1, state=MUTED, dac_code=MID, sample_tick=0, underrun=0.
- Divider:
  - Counter runs 0..DIV-1 and wraps; it runs regardless of state or enable.
  - Internal tick is true while counter==DIV-1.
  - All state/dac_code decisions happen on the edge ending the tick cycle. sample_tick is registered and is high in the following cycle, together with the updated dac_code.
- FIFO:
  - s_ready = (fifo_level != DEPTH), from registered level only; a same-cycle pop does not open space.
  - Push when s_valid && s_ready.
  - Pop only as defined below, at tick.
  - Push and pop in the same cycle leave the level unchanged; data order is preserved.
  - A push in the tick cycle is not visible to that tick's pop decision; decisions use the pre-edge level.
  - Read/write pointers wrap modulo DEPTH.
  - Writes are accepted in every state.
- State MUTED, at each tick:
  - dac_code steps by 1 toward MID (unchanged if already MID).
  - If enable && dac_code==MID && level>=PREFILL: pop, dac_code<=head, go to RUN.
  - The step and the pop are exclusive in one tick: the step applies only if the transition does not occur.
- State RUN, at each tick:
  - If !enable: go to MUTED, no pop, dac_code held this tick.
  - Else if level>0: pop, dac_code<=head.
  - Else: dac_code held, underrun pulses (aligned with sample_tick), go to STARVED.
- State STARVED, at each tick:
  - If !enable: go to MUTED (ramp continues there).
  - Else if level>=PREFILL: pop, dac_code<=head, go to RUN. The output may step from the ramped value to the new sample.
  - Else: dac_code steps by 1 toward MID.
- Ramp arithmetic is 8-bit unsigned compare and +/-1, with no overflow possible.
- underrun is never asserted outside a RUN->STARVED transition.
- Reset mid-operation discards FIFO contents and any ramp. The divider restarts; the first tick after reset is DIV cycles later.

Test Plan:
- Reset: assert rst mid-period during RUN with 3 entries -> immediately dac_code=8'h80, fifo_level=0, s_ready=1, no sample_tick for DIV cycles after release.
- Prefill start (DIV=4, PREFILL=2): enable=1, push 8'h10 only -> dac_code stays 8'h80; push 8'h20 -> next tick dac_code=8'h10, following tick 8'h20, each with sample_tick.
- Underrun: RUN with FIFO drained at last value 8'h20 -> next tick underrun=1, dac_code=8'h20; subsequent ticks 8'h21, 8'h22...; push 2 samples -> resumes with first pushed value, no further underrun pulse.
- Backpressure (DEPTH=4): hold enable=0, s_valid=1 with values 1..6 -> exactly 4 accepted (1..4), s_ready=0, fifo_level=4; enable=1 -> output sequence 1,2,3,4 per tick.
- Mute ramp: RUN at dac_code=8'h83, drop enable -> ticks give 8'h83 (hold), 8'h82, 8'h81, 8'h80, then stays 8'h80; re-enable with level>=PREFILL restarts on next tick.
- Tick-edge push: FIFO empty in RUN, push lands in tick cycle -> underrun=1 that tick, fifo_level=1 afterwards.
